// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter: pulls words from a show-ahead-less FIFO
// and shifts them out one bit per valid/ready handshake.
module piso_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             empty_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic             rd_en_o,
   output logic             sdata_o,
   output logic             svalid_o,
   input  logic             sready_i,
   output logic             sfirst_o,
   output logic             slast_o,
   output logic             busy_o,
   output logic [15:0]      word_cnt_o
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      SHIFT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        word_cnt_q, word_cnt_d;
   logic               rd_en_q, rd_en_d;
   logic               sdata_q, sdata_d;
   logic               svalid_q, svalid_d;
   logic               sfirst_q, sfirst_d;
   logic               slast_q, slast_d;
   logic               busy_q, busy_d;

   // Next-state logic; outputs are derived from next-state values so every port is a flop.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      word_cnt_d = word_cnt_q;

      case (state_q)
         IDLE: begin
            if (!empty_i) state_d = FETCH;
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            shift_d = rdata_i;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (sready_i) begin
               shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
               if (cnt_q == LAST_CNT) begin
                  cnt_d      = '0;
                  word_cnt_d = word_cnt_q + 16'd1;
                  state_d    = empty_i ? IDLE : FETCH;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      rd_en_d  = (state_d == FETCH);
      svalid_d = (state_d == SHIFT);
      sdata_d  = svalid_d & (MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0]);
      sfirst_d = svalid_d && (cnt_d == '0);
      slast_d  = svalid_d && (cnt_d == LAST_CNT);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         word_cnt_q <= '0;
         rd_en_q    <= 1'b0;
         sdata_q    <= 1'b0;
         svalid_q   <= 1'b0;
         sfirst_q   <= 1'b0;
         slast_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         word_cnt_q <= word_cnt_d;
         rd_en_q    <= rd_en_d;
         sdata_q    <= sdata_d;
         svalid_q   <= svalid_d;
         sfirst_q   <= sfirst_d;
         slast_q    <= slast_d;
         busy_q     <= busy_d;
      end
   end

   assign rd_en_o    = rd_en_q;
   assign sdata_o    = sdata_q;
   assign svalid_o   = svalid_q;
   assign sfirst_o   = sfirst_q;
   assign slast_o    = slast_q;
   assign busy_o     = busy_q;
   assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an MSB-first and an LSB-first serializer, each fed by a small FIFO model.
module tb_piso_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sready = 1'b1;

   logic        empty_m = 1'b1, empty_l = 1'b1;
   logic [7:0]  rdata_m = '0, rdata_l = '0;
   logic        rd_en_m, sdata_m, svalid_m, sfirst_m, slast_m, busy_m;
   logic        rd_en_l, sdata_l, svalid_l, sfirst_l, slast_l, busy_l;
   logic [15:0] wcnt_m, wcnt_l;

   logic [7:0]  q_m[$];
   logic [7:0]  q_l[$];
   int          reads_m = 0, rderr_m = 0, reads_l = 0, rderr_l = 0;
   int          cyc = 0;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
      .clk_i(clk), .rst_i(rst), .empty_i(empty_m), .rdata_i(rdata_m),
      .rd_en_o(rd_en_m), .sdata_o(sdata_m), .svalid_o(svalid_m), .sready_i(sready),
      .sfirst_o(sfirst_m), .slast_o(slast_m), .busy_o(busy_m), .word_cnt_o(wcnt_m)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
      .clk_i(clk), .rst_i(rst), .empty_i(empty_l), .rdata_i(rdata_l),
      .rd_en_o(rd_en_l), .sdata_o(sdata_l), .svalid_o(svalid_l), .sready_i(sready),
      .sfirst_o(sfirst_l), .slast_o(slast_l), .busy_o(busy_l), .word_cnt_o(wcnt_l)
   );

   // FIFO models: pop on the negedge inside the read-strobe cycle, data held for LOAD.
   always @(negedge clk) begin
      if (rd_en_m) begin
         reads_m++;
         if (q_m.size() == 0) rderr_m++;
         else rdata_m = q_m.pop_front();
      end
      empty_m = (q_m.size() == 0);
      if (rd_en_l) begin
         reads_l++;
         if (q_l.size() == 0) rderr_l++;
         else rdata_l = q_l.pop_front();
      end
      empty_l = (q_l.size() == 0);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic get_bit(input bit sel, output logic b, output logic f, output logic l,
                          output int t);
      int n;
      n = 0;
      tick();
      while (!((sel ? svalid_l : svalid_m) && sready) && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) chk("bit_wait_timeout", 32'(n), 32'd0);
      b = sel ? sdata_l : sdata_m;
      f = sel ? sfirst_l : sfirst_m;
      l = sel ? slast_l : slast_m;
      t = cyc;
   endtask

   task automatic get_word(input bit sel, output logic [7:0] w, output logic [7:0] fv,
                           output logic [7:0] lv, output int t0, output int t1);
      logic b, f, l;
      int   t;
      w = '0; fv = '0; lv = '0; t0 = 0; t1 = 0;
      for (int i = 0; i < 8; i++) begin
         get_bit(sel, b, f, l, t);
         w  = {w[6:0], b};
         fv = {fv[6:0], f};
         lv = {lv[6:0], l};
         if (i == 0) t0 = t;
         t1 = t;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_rd_en", 32'(rd_en_m), 32'd0);
      chk("rst_svalid", 32'(svalid_m), 32'd0);
      chk("rst_sdata", 32'(sdata_m), 32'd0);
      chk("rst_flags", 32'({sfirst_m, slast_m, busy_m}), 32'd0);
      chk("rst_wcnt", 32'(wcnt_m), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] w, fv, lv;
      logic       b, f, l, held, act;
      int         t0, t1, t2, t3, r0;

      // Reset and long idle with an empty FIFO
      do_reset();
      act = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         act = act | rd_en_m | svalid_m | busy_m | rd_en_l | svalid_l | busy_l;
      end
      chk("idle_quiet", 32'(act), 32'd0);

      // 0xA5 MSB first
      q_m.push_back(8'hA5);
      get_word(1'b0, w, fv, lv, t0, t1);
      chk("a5_msb_bits", 32'(w), 32'hA5);
      chk("a5_msb_first", 32'(fv), 32'h80);
      chk("a5_msb_last", 32'(lv), 32'h01);
      chk("a5_msb_span", 32'(t1 - t0), 32'd7);
      repeat (3) tick();
      chk("a5_msb_wcnt", 32'(wcnt_m), 32'd1);
      chk("a5_msb_idle", 32'({busy_m, svalid_m}), 32'd0);
      chk("a5_msb_reads", 32'(reads_m), 32'd1);

      // LSB first: 0xA5 then 0x01
      q_l.push_back(8'hA5);
      get_word(1'b1, w, fv, lv, t0, t1);
      chk("a5_lsb_bits", 32'(w), 32'hA5);
      chk("a5_lsb_first", 32'(fv), 32'h80);
      chk("a5_lsb_last", 32'(lv), 32'h01);
      q_l.push_back(8'h01);
      get_word(1'b1, w, fv, lv, t0, t1);
      chk("01_lsb_bits", 32'(w), 32'h80);
      repeat (3) tick();
      chk("lsb_wcnt", 32'(wcnt_l), 32'd2);
      chk("lsb_idle", 32'(busy_l), 32'd0);

      // Back-to-back words 0x3C, 0xC3
      do_reset();
      r0 = reads_m;
      q_m.push_back(8'h3C);
      q_m.push_back(8'hC3);
      get_word(1'b0, w, fv, lv, t0, t1);
      chk("b2b_w1", 32'(w), 32'h3C);
      get_word(1'b0, w, fv, lv, t2, t3);
      chk("b2b_w2", 32'(w), 32'hC3);
      chk("b2b_gap", 32'(t2 - t1), 32'd3);
      chk("b2b_w2_span", 32'(t3 - t2), 32'd7);
      repeat (4) tick();
      chk("b2b_reads", 32'(reads_m - r0), 32'd2);
      chk("b2b_wcnt", 32'(wcnt_m), 32'd2);
      chk("b2b_idle", 32'(busy_m), 32'd0);
      chk("b2b_no_rderr", 32'(rderr_m), 32'd0);

      // Backpressure at bit 4 of 0xA5
      q_m.push_back(8'hA5);
      w = '0;
      for (int i = 0; i < 3; i++) begin
         get_bit(1'b0, b, f, l, t0);
         w = {w[6:0], b};
      end
      tick();
      sready = 1'b0;
      held = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         held = held & (sdata_m === 1'b0) & (svalid_m === 1'b1) &
                (sfirst_m === 1'b0) & (slast_m === 1'b0);
      end
      w = {w[6:0], sdata_m};
      sready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         get_bit(1'b0, b, f, l, t0);
         w = {w[6:0], b};
      end
      chk("stall_hold", 32'(held), 32'd1);
      chk("stall_word", 32'(w), 32'hA5);
      repeat (3) tick();
      chk("stall_wcnt", 32'(wcnt_m), 32'd3);

      // Reset mid-word of 0xFF, then 0x81
      q_m.push_back(8'hFF);
      for (int i = 0; i < 3; i++) get_bit(1'b0, b, f, l, t0);
      tick();
      rst = 1'b1;
      r0 = reads_m;
      tick();
      rst = 1'b0;
      chk("midrst_outs", 32'({rd_en_m, svalid_m, sdata_m, sfirst_m, slast_m, busy_m}), 32'd0);
      chk("midrst_wcnt", 32'(wcnt_m), 32'd0);
      repeat (5) tick();
      chk("midrst_no_refetch", 32'(reads_m - r0), 32'd0);
      chk("midrst_idle", 32'(busy_m), 32'd0);
      q_m.push_back(8'h81);
      get_word(1'b0, w, fv, lv, t0, t1);
      chk("post_rst_bits", 32'(w), 32'h81);
      chk("post_rst_first", 32'(fv), 32'h80);
      chk("post_rst_last", 32'(lv), 32'h01);
      repeat (3) tick();
      chk("post_rst_wcnt", 32'(wcnt_m), 32'd1);
      chk("no_read_errors", 32'(rderr_m + rderr_l), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: FIFO word width, bits per serialized word.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 SHALL have port clk_i, input, 1: single clock, the FIFO read clock; all logic on posedge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port empty_i, input, 1: FIFO empty flag.
REQ-006 SHALL have port rdata_i, input, WIDTH: FIFO read data, valid the cycle after a rd_en_o cycle.
REQ-007 SHALL have port rd_en_o, output, 1: FIFO read strobe.
REQ-008 SHALL have port sdata_o, output, 1: serial data bit.
REQ-009 SHALL have port svalid_o, output, 1: sdata_o carries a valid bit.
REQ-010 SHALL have port sready_i, input, 1: downstream accepts the bit on this edge.
REQ-011 SHALL have port sfirst_o, output, 1: current bit is the first bit of a word.
REQ-012 SHALL have port slast_o, output, 1: current bit is the last bit of a word.
REQ-013 SHALL have port busy_o, output, 1: state is not IDLE.
REQ-014 SHALL have port word_cnt_o, output, 16: count of fully transmitted words, wraps 0xFFFF->0.

Function
REQ-015 SHALL implement a state machine IDLE, FETCH, LOAD, SHIFT; all outputs registered or decoded from state and registers only (no input-to-output combinational path).
REQ-016 IDLE: rd_en_o=0, svalid_o=0; if empty_i=0 -> FETCH, else stay.
REQ-017 FETCH: rd_en_o=1 for exactly one cycle -> LOAD unconditionally.
REQ-018 LOAD: shift register <= rdata_i, bit counter <= 0 -> SHIFT.
REQ-019 SHIFT: svalid_o=1; sdata_o = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0).
REQ-020 Handshake: a bit transfers on an edge where svalid_o=1 and sready_i=1; sdata_o, sfirst_o, slast_o SHALL hold stable while sready_i=0.
REQ-021 On each transfer: shift register shifts one place toward the output end, counter increments.
REQ-022 sfirst_o=1 when counter=0 in SHIFT; slast_o=1 when counter=WIDTH-1 in SHIFT; both 0 otherwise.
REQ-023 Counter width SHALL be $clog2(WIDTH) bits; the transfer at WIDTH-1 ends the word with no overflow.
REQ-024 On the last-bit transfer: word_cnt_o increments; next state FETCH if empty_i=0, else IDLE.
REQ-025 rd_en_o SHALL never be 1 while empty_i=1 (the FIFO never sees a read error from this block).
REQ-026 Word-to-word gap with sready_i held 1: exactly 2 cycles with svalid_o=0 (FETCH, LOAD) between the last bit of one word and the first bit of the next.
REQ-027 Minimum latency: empty_i falls at edge N -> FETCH at N+1, LOAD at N+2, first bit valid after N+3.
REQ-028 sready_i SHALL be ignored outside SHIFT.
REQ-029 This block is the sole reader of the FIFO; empty_i is not re-sampled in FETCH.

Reset
REQ-030 When rst_i=1 at a posedge: state=IDLE, rd_en_o=0, svalid_o=0, sdata_o=0, sfirst_o=0, slast_o=0, busy_o=0, word_cnt_o=0, shift register=0, counter=0.
REQ-031 Reset mid-word SHALL discard the partial word (it is not re-fetched) and takes priority over every other transition.
REQ-032 rd_en_o SHALL be 0 in the cycle that follows any reset edge.

Verification
REQ-033 FIFO holds 0xA5, MSB_FIRST=1, sready_i=1 -> one rd_en_o pulse; sdata_o = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; sfirst_o on bit 1, slast_o on bit 8; word_cnt_o=1; return to IDLE.
REQ-034 Same 0xA5 with MSB_FIRST=0 -> sdata_o = 1,0,1,0,0,1,0,1 (LSB first, palindrome check); repeat with 0x01 -> 1,0,0,0,0,0,0,0.
REQ-035 FIFO holds 0x3C then 0xC3, sready_i=1 -> 00111100, 2 idle cycles, 11000011; exactly 2 rd_en_o pulses; word_cnt_o=2; empty_i=1 -> IDLE, never rd_en_o while empty.
REQ-036 0xA5 with sready_i low for 3 cycles at bit 4 -> sdata_o=0 held all 3 cycles, svalid_o stays 1, remaining bits unchanged in order.
REQ-037 rst_i=1 for one cycle after bit 3 of 0xFF -> all outputs 0 next cycle, word_cnt_o=0; next FIFO word 0x81 serializes fully and correctly.
REQ-038 empty_i held 1 for 100 cycles after reset -> rd_en_o, svalid_o, busy_o stay 0 throughout.
